operand_loader: RTL and testbench
=================================

# operand_loader

Front-end operand capture stage for the signed 2-bit multiplier datapath. It takes a 2-bit switch bank and a single "load" push-button from the board, then synchronises and debounces the button. A two-step state machine latches the first press as operand a and the second press as operand b. It presents both as signed 2-bit values with a valid flag directly to the multiplier inputs, and drives two status LEDs.

## Interface

- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before the debounced button level changes (10 ms at 50 MHz); legal range 2..2^24
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-high reset
- sw  input  2  raw operand switches, two's complement, sampled at capture
- btn_load  input  1  raw asynchronous push-button, high = pressed
- a  output  2  signed operand a, to multiplier input a
- b  output  2  signed operand b, to multiplier input b
- operands_valid  output  1  high while a and b form a complete, freshly entered pair
- led_wait_a  output  1  high in state WAIT_A
- led_wait_b  output  1  high in state WAIT_B

## Operation

- Synchroniser: btn_load passes through two flops to give btn_sync. Both flops reset to 0.
- Debouncer: db_level resets to 0 and cnt resets to 0.
  - When btn_sync equals db_level, cnt clears to 0.
  - When they differ, cnt increments.
  - When they differ and cnt equals DEBOUNCE_CYCLES-1, db_level toggles and cnt clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1. The counter never wraps.
- Edge detect: load_p is registered and equals db_level AND NOT db_level_q, giving one pulse per debounced press. The release edge produces no pulse.
- FSM states are WAIT_A, WAIT_B and DONE. Reset state is WAIT_A.
  - WAIT_A + load_p: a <= sw, go to WAIT_B.
  - WAIT_B + load_p: b <= sw, operands_valid <= 1, go to DONE.
  - DONE + load_p: a <= sw, operands_valid <= 0, b unchanged, go to WAIT_B.
  - No load_p: state and all outputs hold.
- sw is sampled only on the cycle that load_p is high. Switch changes at any other time have no effect.
- LEDs are decoded from the state register: led_wait_a = (state==WAIT_A), led_wait_b = (state==WAIT_B). Both are low in DONE.
- a and b are plain copies of sw bits. Sign interpretation (range -2..+1) belongs to the consumer.

## Timing

- Reset values:
  - a=2'b00, b=2'b00
  - operands_valid=0
  - led_wait_a=1, led_wait_b=0
  - state=WAIT_A
  - all internal registers = 0
- Reset applied mid-press: everything returns to the reset values. A button held through reset release must first be seen stable-high for DEBOUNCE_CYCLES cycles before a pulse occurs. A held button is never mistaken for an immediate press.
- Latency: btn_load first sampled high at edge N and held stable:
  - btn_sync high after edge N+1
  - db_level high after edge N+1+DEBOUNCE_CYCLES
  - load_p high after edge N+2+DEBOUNCE_CYCLES
  - a/b/state/valid update at edge N+3+DEBOUNCE_CYCLES
- Glitches shorter than DEBOUNCE_CYCLES cycles (a return to db_level at any point) reset cnt and produce no pulse.
- load_p is high for exactly one cycle per press, so there is at most one FSM transition per press.
- reset has priority over load_p in the same cycle.

## Configuration

- DEBOUNCE_EN defined: the debouncer is built exactly as described above.
- DEBOUNCE_EN undefined:
  - db_level = btn_sync directly; no counter is present and DEBOUNCE_CYCLES is ignored.
  - Latency from edge N to update becomes edge N+3.
  - Every synchronised rising edge, bounce included, produces a load_p. This mode is for simulation only.

## Test plan

- Reset, DEBOUNCE_CYCLES=4, DEBOUNCE_EN defined: check reset values.
  - Required: a=00, b=00, operands_valid=0, led_wait_a=1, led_wait_b=0.
- Enter a pair: sw=2'b11 then hold btn 10 cycles and release, then sw=2'b10 then hold btn 10 cycles.
  - Required after the first press: a=11 at exactly edge N+7, led_wait_b=1.
  - Required after the second press: b=10, operands_valid=1, both LEDs 0.
- Bounce rejection: btn toggling high 2 cycles / low 1 cycle for 20 cycles, then low.
  - Required: no state change, a/b unchanged.
- Re-entry from DONE: from a=11, b=10, valid=1, set sw=01 and press.
  - Required: a=01, b=10, operands_valid=0, state WAIT_B.
- Switch change without a press: with state WAIT_B, toggle sw through all 4 values.
  - Required: a, b and state unchanged.
- Reset mid-operation: reset asserted for 1 cycle while the button is held in WAIT_B, button kept held 10 more cycles.
  - Required: reset values restored.
  - Required: exactly one load_p, 4 stable cycles after reset deasserts, landing a=sw and state WAIT_B.
  - Required with DEBOUNCE_EN undefined: the same bounce stimulus yields multiple transitions.

Source files
------------

// File: rtl/operand_loader_if.sv
// Board-side bus of the operand loader: raw switches/button in, signed operands and status LEDs out.
interface operand_loader_if;
  logic [1:0] sw;
  logic       btn_load;
  logic [1:0] a;
  logic [1:0] b;
  logic       operands_valid;
  logic       led_wait_a;
  logic       led_wait_b;

  modport slave (
    input  sw, btn_load,
    output a, b, operands_valid, led_wait_a, led_wait_b
  );

  modport master (
    output sw, btn_load,
    input  a, b, operands_valid, led_wait_a, led_wait_b
  );
endinterface

// File: rtl/operand_loader.sv
// Operand capture: sync + debounce the load button, latch a then b from the switches.
// Build option: DEBOUNCE_EN enables the stability counter; without it the synced button is used raw.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  operand_loader_if.slave  io
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_cfg
    $error("operand_loader: DEBOUNCE_CYCLES outside 2..2^24");
  end

  typedef enum logic [1:0] {WAIT_A, WAIT_B, DONE} state_e;

  // two-flop synchroniser for the asynchronous push-button
  logic [1:0] sync_q, sync_d;
  logic       btn_sync;

  always_comb begin
    sync_d = {sync_q[0], io.btn_load};
  end

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign btn_sync = sync_q[1];

  logic db_level;

`ifdef DEBOUNCE_EN
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          db_lvl_q, db_lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // any sample matching the current level restarts the stability count
  always_comb begin
    db_lvl_d = db_lvl_q;
    cnt_d    = '0;
    if (btn_sync != db_lvl_q) begin
      if (cnt_q == CNT_MAX) db_lvl_d = ~db_lvl_q;
      else                  cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_lvl_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      db_lvl_q <= db_lvl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign db_level = db_lvl_q;
`else
  assign db_level = btn_sync;
`endif

  // rising-edge detect on the debounced level: one pulse per press
  logic db_prev_q, db_prev_d;
  logic load_p_q, load_p_d;

  always_comb begin
    db_prev_d = db_level;
    load_p_d  = db_level & ~db_prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q <= 1'b0;
      load_p_q  <= 1'b0;
    end else begin
      db_prev_q <= db_prev_d;
      load_p_q  <= load_p_d;
    end
  end

  state_e     state_q, state_d;
  logic [1:0] a_q, a_d, b_q, b_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (load_p_q) begin
      case (state_q)
        WAIT_A: begin
          a_d     = io.sw;
          state_d = WAIT_B;
        end
        WAIT_B: begin
          b_d     = io.sw;
          valid_d = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          // a new a invalidates the pair; old b is kept until replaced
          a_d     = io.sw;
          valid_d = 1'b0;
          state_d = WAIT_B;
        end
        default: begin
          state_d = WAIT_A;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_A;
      a_q     <= 2'b00;
      b_q     <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign io.a              = a_q;
  assign io.b              = b_q;
  assign io.operands_valid = valid_q;
  assign io.led_wait_a     = (state_q == WAIT_A);
  assign io.led_wait_b     = (state_q == WAIT_B);

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: history-based reference model checked every cycle, plus directed literal checks.
module tb_operand_loader;
  localparam int D = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT   = D + 3;
  localparam bit DB_ON = 1'b1;
`else
  localparam int LAT   = 3;
  localparam bit DB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_loader_if bus();

  operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw button / sync / debounced level are kept as per-edge histories
  // (index = edges since the last reset edge); operands follow from the press count.
  logic       btn_hist   [0:4095];
  logic       sync_hist  [0:4095];
  logic       level_hist [0:4095];
  int         k        = 0;
  int         m_press  = 0;
  logic [1:0] m_a      = 2'b00;
  logic [1:0] m_b      = 2'b00;
  bit         model_ok = 1'b0;

  // Level flips once the last D synced samples all disagree with it.
  function automatic logic next_level(input int kk);
`ifdef DEBOUNCE_EN
    logic lvl;
    bit   all_diff;
    lvl = level_hist[kk-1];
    if (kk < D) return lvl;
    all_diff = 1'b1;
    for (int i = kk - D; i < kk; i++)
      if (sync_hist[i] == lvl) all_diff = 1'b0;
    return all_diff ? ~lvl : lvl;
`else
    return sync_hist[kk];
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      k             = 0;
      m_press       = 0;
      m_a           = 2'b00;
      m_b           = 2'b00;
      sync_hist[0]  = 1'b0;
      level_hist[0] = 1'b0;
      model_ok      = 1'b1;
    end else if (model_ok) begin
      k = k + 1;
      btn_hist[k-1] = bus.btn_load;
      sync_hist[k]  = (k >= 2) ? btn_hist[k-2] : 1'b0;
      level_hist[k] = next_level(k);
      // press acts at the edge after the pulse that follows a debounced rise
      if (k >= 3 && level_hist[k-2] && !level_hist[k-3]) begin
        m_press = m_press + 1;
        if (m_press % 2 == 1) m_a = bus.sw;
        else                  m_b = bus.sw;
      end
    end
  end

  always @(negedge clk) begin
    logic [6:0] exp_v, act_v;
    if (model_ok) begin
      exp_v = {m_a, m_b, (m_press >= 2 && m_press % 2 == 0),
               (m_press == 0), (m_press % 2 == 1)};
      act_v = {bus.a, bus.b, bus.operands_valid, bus.led_wait_a, bus.led_wait_b};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t {a,b,valid,lwa,lwb} actual=%b expected=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] v, input int hold);
    bus.sw       = v;
    bus.btn_load = 1'b1;
    cyc(hold);
    bus.btn_load = 1'b0;
    cyc(12);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"},     32'(bus.a), 0);
    chk({tag, "_b"},     32'(bus.b), 0);
    chk({tag, "_valid"}, 32'(bus.operands_valid), 0);
    chk({tag, "_lwa"},   32'(bus.led_wait_a), 1);
    chk({tag, "_lwb"},   32'(bus.led_wait_b), 0);
  endtask

  initial begin
    logic [2:0] prev;
    int         tr;

    reset        = 1'b1;
    bus.sw       = 2'b00;
    bus.btn_load = 1'b0;
    cyc(3);
    reset = 1'b0;
    chk_reset_vals("reset");

    // first press: a must change at exactly N+LAT
    bus.sw       = 2'b11;
    bus.btn_load = 1'b1;
    cyc(LAT);
    chk("a_before_latency", 32'(bus.a), 0);
    chk("lwa_before_latency", 32'(bus.led_wait_a), 1);
    cyc(1);
    chk("a_at_latency", 32'(bus.a), 3);
    chk("lwb_after_first", 32'(bus.led_wait_b), 1);
    chk("lwa_after_first", 32'(bus.led_wait_a), 0);
    cyc(10 - LAT - 1);
    bus.btn_load = 1'b0;
    cyc(12);

    press(2'b10, 10);
    chk("pair_a", 32'(bus.a), 3);
    chk("pair_b", 32'(bus.b), 2);
    chk("pair_valid", 32'(bus.operands_valid), 1);
    chk("pair_lwa", 32'(bus.led_wait_a), 0);
    chk("pair_lwb", 32'(bus.led_wait_b), 0);

    press(2'b01, 10);
    chk("reentry_a", 32'(bus.a), 1);
    chk("reentry_b", 32'(bus.b), 2);
    chk("reentry_valid", 32'(bus.operands_valid), 0);
    chk("reentry_lwb", 32'(bus.led_wait_b), 1);

    for (int v = 0; v < 4; v++) begin
      bus.sw = 2'(v);
      cyc(2);
      chk("sw_sweep_a", 32'(bus.a), 1);
      chk("sw_sweep_b", 32'(bus.b), 2);
      chk("sw_sweep_lwb", 32'(bus.led_wait_b), 1);
    end

    // bounce: high 2 / low 1; with the raw path each rise is a press (7 of them, sw=3)
    tr   = 0;
    prev = {bus.led_wait_a, bus.led_wait_b, bus.operands_valid};
    for (int i = 0; i < 32; i++) begin
      bus.btn_load = (i < 20) && (i % 3 != 2);
      cyc(1);
      if ({bus.led_wait_a, bus.led_wait_b, bus.operands_valid} != prev) tr++;
      prev = {bus.led_wait_a, bus.led_wait_b, bus.operands_valid};
    end
    chk("bounce_transitions", 32'(tr), DB_ON ? 0 : 7);
    chk("bounce_a", 32'(bus.a), DB_ON ? 1 : 3);
    chk("bounce_b", 32'(bus.b), DB_ON ? 2 : 3);

    // reset while the button is held, then keep holding
    bus.sw       = 2'b10;
    bus.btn_load = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_reset_vals("midreset");
    bus.sw = 2'b11;
    tr     = 0;
    prev   = {bus.led_wait_a, bus.led_wait_b, bus.operands_valid};
    for (int i = 0; i < 22; i++) begin
      if (i == 10) bus.btn_load = 1'b0;
      cyc(1);
      if ({bus.led_wait_a, bus.led_wait_b, bus.operands_valid} != prev) tr++;
      prev = {bus.led_wait_a, bus.led_wait_b, bus.operands_valid};
    end
    chk("midreset_transitions", 32'(tr), 1);
    chk("midreset_a", 32'(bus.a), 3);
    chk("midreset_b", 32'(bus.b), 0);
    chk("midreset_lwb", 32'(bus.led_wait_b), 1);
    chk("midreset_valid", 32'(bus.operands_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
